// File: rtl/can_bridge_pkg.sv
// can_bridge_pkg: shared types and field lengths
// for the CAN receive scheduler.
package can_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID,
    ST_CTRL,
    ST_DATA,
    ST_CRC,
    ST_ACK,
    ST_EOF
  } can_state_e;

  localparam int ID_BITS   = 11;
  localparam int CTRL_BITS = 8;
  localparam int CRC_BITS  = 11;
  localparam int EOF_BITS  = 7;
  localparam int IDLE_BITS = 11;
  localparam int MAX_DLC   = 8;

  function automatic logic [3:0] clamp_dlc(
    input logic [3:0] raw
  );
    return (raw > 4'(MAX_DLC)) ? 4'(MAX_DLC) : raw;
  endfunction

endpackage

// File: rtl/can_byte_fifo.sv
// can_byte_fifo: first-word-fall-through byte FIFO
// with a sticky overflow flag for dropped pushes.
module can_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       valid_o,
  output logic       ovf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          ovf_q;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty;
  // A pop in the same clock frees the slot.
  assign do_push = push_i && (!full || do_pop);

  assign rdata_o = empty ? 8'h00 : mem_q[rd_q];
  assign valid_o = !empty;
  assign ovf_o   = ovf_q;

  // Occupancy next-state from push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array, written on accepted push.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      if (push_i && !do_push) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/can_rx_sched.sv
// can_rx_sched: CAN receive bit scheduler. Hard-syncs
// on SOF, samples once per bit, pushes data bytes.
module can_rx_sched
  import can_bridge_pkg::*;
#(
  parameter int BIT_CLKS   = 10,
  parameter int SAMPLE_PT  = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Can_rx,
  output logic       R_frame,
  output logic       frame_active,
  output logic [3:0] dlc,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_done,
  output logic       frame_error,
  output logic       overflow
);

  localparam logic [15:0] IDLE_CLKS =
    16'(IDLE_BITS * BIT_CLKS);
  localparam logic [7:0] TQ_LAST = 8'(BIT_CLKS - 1);
  localparam logic [7:0] TQ_SMP  = 8'(SAMPLE_PT);

  logic [2:0]  sync_q;
  logic        rxs;
  logic        rxs_prev;
  logic [15:0] idle_cnt_q;
  logic        bus_idle_q;
  can_state_e  state_q;
  logic [7:0]  tq_q;
  logic [6:0]  bit_q;
  logic [6:0]  sh_q;
  logic [3:0]  dlc_q;
  logic        active_q;
  logic        done_q;
  logic        err_q;

  logic        smp;
  logic        sof_ok;
  logic        eof_bad;
  logic        start;
  logic        push;
  logic [3:0]  dlc_new;
  logic [6:0]  data_last;
  logic [7:0]  byte_new;

  assign rxs      = sync_q[1];
  assign rxs_prev = sync_q[2];

  assign smp     = (state_q != ST_IDLE) && (tq_q == TQ_SMP);
  assign sof_ok  = smp && (state_q == ST_SOF) && !rxs;
  assign eof_bad = smp && (state_q == ST_EOF) && !rxs;
  assign start   = (state_q == ST_IDLE) && bus_idle_q
                && rxs_prev && !rxs;

  assign dlc_new   = clamp_dlc({sh_q[2:0], rxs});
  assign data_last = {dlc_q, 3'b000} - 7'd1;
  assign byte_new  = {sh_q, rxs};
  assign push      = smp && (state_q == ST_DATA)
                  && (bit_q[2:0] == 3'b111);

  assign R_frame      = smp;
  assign frame_active = active_q;
  assign dlc          = dlc_q;
  assign frame_done   = done_q;
  assign frame_error  = err_q;

  // Two-flop synchroniser plus one delay for edge detect.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], Can_rx};
  end

  // Recessive run counter and sticky bus-idle flag;
  // a SOF glitch leaves the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt_q <= '0;
      bus_idle_q <= 1'b0;
    end else begin
      if (!rxs || eof_bad)
        idle_cnt_q <= '0;
      else if (idle_cnt_q != IDLE_CLKS)
        idle_cnt_q <= idle_cnt_q + 16'd1;
      if (sof_ok || eof_bad)
        bus_idle_q <= 1'b0;
      else if (rxs && idle_cnt_q == IDLE_CLKS - 16'd1)
        bus_idle_q <= 1'b1;
    end
  end

  // Frame FSM: bit timing, field walk, registered pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tq_q     <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      dlc_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == ST_IDLE) begin
        tq_q  <= '0;
        bit_q <= '0;
        if (start) state_q <= ST_SOF;
      end else begin
        tq_q <= (tq_q == TQ_LAST) ? 8'd0 : tq_q + 8'd1;
        if (smp) begin
          sh_q  <= {sh_q[5:0], rxs};
          bit_q <= bit_q + 7'd1;
          unique case (state_q)
            ST_SOF: begin
              bit_q <= '0;
              if (rxs) begin
                state_q <= ST_IDLE;
              end else begin
                state_q  <= ST_ID;
                active_q <= 1'b1;
              end
            end
            ST_ID: begin
              if (bit_q == 7'(ID_BITS - 1)) begin
                bit_q   <= '0;
                state_q <= ST_CTRL;
              end
            end
            ST_CTRL: begin
              if (bit_q == 7'(CTRL_BITS - 1)) begin
                bit_q   <= '0;
                dlc_q   <= dlc_new;
                state_q <= (dlc_new == 4'd0) ? ST_CRC
                                             : ST_DATA;
              end
            end
            ST_DATA: begin
              if (bit_q == data_last) begin
                bit_q   <= '0;
                state_q <= ST_CRC;
              end
            end
            ST_CRC: begin
              if (bit_q == 7'(CRC_BITS - 1)) begin
                bit_q   <= '0;
                state_q <= ST_ACK;
              end
            end
            ST_ACK: begin
              bit_q   <= '0;
              state_q <= ST_EOF;
            end
            ST_EOF: begin
              if (!rxs) begin
                err_q    <= 1'b1;
                active_q <= 1'b0;
                state_q  <= ST_IDLE;
              end else if (bit_q == 7'(EOF_BITS - 1)) begin
                done_q   <= 1'b1;
                active_q <= 1'b0;
                state_q  <= ST_IDLE;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  can_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (byte_new),
    .pop_i   (m_ready),
    .rdata_o (m_data),
    .valid_o (m_valid),
    .ovf_o   (overflow)
  );

endmodule

// File: tb/tb_can_rx_sched.sv
// tb_can_rx_sched: frame-level stimulus against a
// field/length reference model of the CAN receiver.
module tb_can_rx_sched;

  localparam int BC = 10;
  localparam int SP = 6;
  localparam int FD = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       Can_rx = 1'b1;
  logic       m_ready = 1'b0;
  logic       R_frame;
  logic       frame_active;
  logic [3:0] dlc;
  logic [7:0] m_data;
  logic       m_valid;
  logic       frame_done;
  logic       frame_error;
  logic       overflow;

  can_rx_sched #(
    .BIT_CLKS(BC),
    .SAMPLE_PT(SP),
    .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .Can_rx(Can_rx),
    .R_frame(R_frame),
    .frame_active(frame_active),
    .dlc(dlc),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .frame_done(frame_done),
    .frame_error(frame_error),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int npass = 0;
  int nchk  = 0;
  bit rdy_rand = 0;

  logic [10:0] f_id;
  logic [7:0]  f_ctrl;
  logic [7:0]  f_data [8];
  logic [10:0] f_crc;
  int          f_bad;

  int cyc = 0;
  int n_rf, gap_bad, n_done, n_err, act_bad;
  int first_rf, last_rf, ctrl_end, done_cyc, act_cyc;
  bit act_seen;
  logic [7:0] rxq [$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (R_frame) begin
      if (n_rf > 0 && cyc - last_rf != BC) gap_bad++;
      if (n_rf == 0) first_rf = cyc;
      if (n_rf == 19) ctrl_end = cyc;
      last_rf = cyc;
      n_rf++;
    end
    if (frame_active && !act_seen) begin
      act_seen = 1;
      act_cyc  = cyc;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
      if (frame_active) act_bad++;
    end
    if (frame_error) begin
      n_err++;
      if (frame_active) act_bad++;
    end
    if (m_valid && m_ready) rxq.push_back(m_data);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clr_mon();
    n_rf = 0; gap_bad = 0; n_done = 0; n_err = 0;
    act_bad = 0; act_seen = 0; first_rf = 0;
    last_rf = 0; ctrl_end = 0; done_cyc = 0;
    act_cyc = 0;
    rxq.delete();
  endtask

  function automatic int exp_dlc();
    return (f_ctrl[3:0] > 4'd8) ? 8 : int'(f_ctrl[3:0]);
  endfunction

  task automatic set_data(input logic [7:0] base);
    for (int k = 0; k < 8; k++) f_data[k] = base + 8'(k);
  endtask

  // nb < 0 drives the whole frame plus a recessive tail.
  task automatic send_frame(input bit do_idle,
                            input int nb);
    bit bq [$];
    int d;
    d = exp_dlc();
    if (do_idle) begin
      Can_rx = 1'b1;
      repeat (12 * BC) tick();
    end
    bq.push_back(1'b0);
    for (int i = 10; i >= 0; i--) bq.push_back(f_id[i]);
    for (int i = 7; i >= 0; i--) bq.push_back(f_ctrl[i]);
    for (int k = 0; k < d; k++)
      for (int i = 7; i >= 0; i--)
        bq.push_back(f_data[k][i]);
    for (int i = 10; i >= 0; i--) bq.push_back(f_crc[i]);
    bq.push_back(1'b1);
    for (int i = 0; i < 7; i++) bq.push_back(i != f_bad);
    foreach (bq[j]) begin
      if (nb >= 0 && j >= nb) break;
      Can_rx = bq[j];
      repeat (BC) tick();
    end
    if (nb < 0) begin
      Can_rx = 1'b1;
      repeat (2 * BC) tick();
    end
  endtask

  task automatic check_frame();
    int d;
    int exp_rf;
    d = exp_dlc();
    exp_rf = (f_bad < 0) ? 39 + 8 * d : 33 + 8 * d + f_bad;
    rdy_rand = 0;
    m_ready  = 1'b1;
    repeat (20) tick();
    check("rframes", n_rf, exp_rf);
    check("gap", gap_bad, 0);
    check("done", n_done, (f_bad < 0) ? 1 : 0);
    check("error", n_err, (f_bad < 0) ? 0 : 1);
    check("dlc", dlc, d);
    check("act_seen", act_seen, 1);
    check("act_lag", act_cyc - first_rf, 1);
    check("act_fall", act_bad, 0);
    check("active", frame_active, 0);
    if (f_bad < 0)
      check("done_lag", done_cyc - ctrl_end,
            (8 * d + 19) * BC + 1);
    check("drained", m_valid, 0);
    check("nbytes", rxq.size(), d);
    for (int k = 0; k < d && k < rxq.size(); k++)
      check($sformatf("byte%0d", k), rxq[k], f_data[k]);
  endtask

  initial begin
    f_bad = -1;
    clr_mon();
    repeat (3) tick();
    check("rst_rframe", R_frame, 0);
    check("rst_active", frame_active, 0);
    check("rst_valid", m_valid, 0);
    check("rst_done", frame_done, 0);
    check("rst_error", frame_error, 0);
    check("rst_ovf", overflow, 0);
    check("rst_dlc", dlc, 0);
    check("rst_mdata", m_data, 0);
    reset = 1'b0;

    // Reference frame, consumer always ready.
    f_id = 11'h7FF; f_ctrl = 8'h08; f_crc = 11'h55B;
    f_bad = -1; set_data(8'h41);
    m_ready = 1'b1;
    clr_mon();
    send_frame(1, -1);
    check_frame();

    // Zero-length and over-length DLC.
    f_ctrl = 8'h00; f_id = 11'h123;
    clr_mon(); send_frame(1, -1); check_frame();
    f_ctrl = 8'h0F; set_data(8'h10);
    clr_mon(); send_frame(1, -1); check_frame();

    // EOF form error on bit 3.
    f_ctrl = 8'h08; set_data(8'h41); f_bad = 3;
    clr_mon(); send_frame(1, -1); check_frame();

    // Random frames with a random consumer.
    for (int n = 0; n < 6; n++) begin
      f_id   = 11'($urandom_range(0, 2047));
      f_ctrl = 8'($urandom_range(0, 255));
      f_crc  = 11'($urandom_range(0, 2047));
      for (int k = 0; k < 8; k++)
        f_data[k] = 8'($urandom_range(0, 255));
      f_bad = ($urandom_range(0, 3) == 0)
            ? int'($urandom_range(0, 6)) : -1;
      clr_mon();
      rdy_rand = 1;
      send_frame(1, -1);
      check_frame();
    end
    check("ovf_clear", overflow, 0);

    // Two-clock glitch, then a frame without a new idle.
    Can_rx = 1'b1;
    repeat (12 * BC) tick();
    clr_mon();
    Can_rx = 1'b0;
    tick(); tick();
    Can_rx = 1'b1;
    repeat (3 * BC) tick();
    check("glitch_rf", n_rf, 1);
    check("glitch_act", act_seen, 0);
    f_id = 11'h2A5; f_ctrl = 8'h03; f_bad = -1;
    set_data(8'hA0);
    clr_mon(); send_frame(0, -1); check_frame();

    // Reset during data byte 4.
    f_ctrl = 8'h08; set_data(8'h41); f_bad = -1;
    m_ready = 1'b0;
    clr_mon();
    send_frame(1, 48);
    check("pre_valid", m_valid, 1);
    check("pre_active", frame_active, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_valid", m_valid, 0);
    check("rst_mid_active", frame_active, 0);
    clr_mon();
    Can_rx = 1'b1;
    repeat (3 * BC) tick();
    Can_rx = 1'b0;
    repeat (BC) tick();
    Can_rx = 1'b1;
    repeat (5 * BC) tick();
    check("early_sof_rf", n_rf, 0);
    check("early_sof_act", act_seen, 0);
    m_ready = 1'b1;
    clr_mon(); send_frame(1, -1); check_frame();

    // Back-to-back frames into a stalled consumer.
    m_ready = 1'b0;
    clr_mon();
    set_data(8'h41); send_frame(1, -1);
    set_data(8'h51); send_frame(1, -1);
    check("ovf_set", overflow, 1);
    check("ovf_valid", m_valid, 1);
    check("ovf_head", m_data, 8'h41);
    check("ovf_dones", n_done, 2);
    m_ready = 1'b1;
    repeat (20) tick();
    check("ovf_nbytes", rxq.size(), 8);
    for (int k = 0; k < 8 && k < rxq.size(); k++)
      check($sformatf("ovf_byte%0d", k), rxq[k],
            8'h41 + 8'(k));
    check("ovf_sticky", overflow, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
